// File: rtl/add_pipe_if.sv
// rtl/add_pipe_if.sv - operand/result handshake bundle for add_pipe
interface add_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, out, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, out, cout, ovf, zero
  );
endinterface

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined two's-complement adder/subtractor with sliced carry chain
module add_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic      clk,
  input  logic      reset,
  add_pipe_if.slave bus
);
  // SW: bits resolved per stage; PS: number of intermediate (non-output) stages, min 1
  localparam int SW = WIDTH / STAGES;
  localparam int PS = (STAGES > 1) ? STAGES - 1 : 1;

  // Intermediate stage registers: operands travel with the partial sum and slice carry
  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_opa [PS];
  logic [WIDTH-1:0]  r_opb [PS];
  logic [WIDTH-1:0]  r_sum [PS];
  logic [PS-1:0]     r_cry;

  // Final stage registers drive the result port directly
  logic [WIDTH-1:0]  r_out;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;

  // Per-stage inputs and combinational slice results
  logic [WIDTH-1:0]  w_opa [STAGES];
  logic [WIDTH-1:0]  w_opb [STAGES];
  logic [WIDTH-1:0]  w_sin [STAGES];
  logic [WIDTH-1:0]  w_sum [STAGES];
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_cry;
  logic [SW:0]       w_slice [STAGES];
  logic              w_stall;
  logic              w_ovf;
  logic              w_zero;

  // The whole pipe holds as one unit whenever a finished result is not taken
  assign w_stall      = r_vld[STAGES-1] & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;

  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.out       = r_out;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

  // Select each stage's inputs: stage 0 from the port (subtract folded in), others from the previous register
  always_comb begin
    w_opa[0] = bus.a;
    w_opb[0] = bus.sub ? ~bus.b : bus.b;
    w_sin[0] = '0;
    w_cin[0] = bus.cin ^ bus.sub;
    for (int k = 1; k < STAGES; k++) begin
      w_opa[k] = r_opa[k-1];
      w_opb[k] = r_opb[k-1];
      w_sin[k] = r_sum[k-1];
      w_cin[k] = r_cry[k-1];
    end
  end

  // Add slice k of each stage and splice it into the partial sum; lower slices pass unchanged
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_slice[k] = {1'b0, w_opa[k][k*SW +: SW]} + {1'b0, w_opb[k][k*SW +: SW]}
                   + {{SW{1'b0}}, w_cin[k]};
      w_sum[k]   = w_sin[k];
      w_sum[k][k*SW +: SW] = w_slice[k][SW-1:0];
      w_cry[k]   = w_slice[k][SW];
    end
  end

  // Carry into the MSB is recovered as a^b^sum at that bit, so ovf needs no extra adder split
  always_comb begin
    w_ovf  = w_opa[STAGES-1][WIDTH-1] ^ w_opb[STAGES-1][WIDTH-1]
           ^ w_sum[STAGES-1][WIDTH-1] ^ w_cry[STAGES-1];
    w_zero = (w_sum[STAGES-1] == '0);
  end

  // Advance every stage together unless stalled; reset flushes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld  <= '0;
      r_cry  <= '0;
      r_out  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < PS; k++) begin
        r_opa[k] <= '0;
        r_opb[k] <= '0;
        r_sum[k] <= '0;
      end
    end else if (!w_stall) begin
      r_vld[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        r_opa[k] <= w_opa[k];
        r_opb[k] <= w_opb[k];
        r_sum[k] <= w_sum[k];
        r_cry[k] <= w_cry[k];
      end
      r_out  <= w_sum[STAGES-1];
      r_cout <= w_cry[STAGES-1];
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
    end
  end
endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - self-checking bench for add_pipe at three parameter points
module tb_add_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Drive/sample arrays: index 0 = 16/4, 1 = 8/1, 2 = 32/8
  logic [2:0]  d_valid, d_oready, d_sub, d_cin;
  logic [31:0] d_a [3];
  logic [31:0] d_b [3];
  logic [2:0]  s_ready, s_ovalid;
  logic [34:0] s_res [3];

  add_pipe_if #(.WIDTH(16)) if16 ();
  add_pipe_if #(.WIDTH(8))  if8 ();
  add_pipe_if #(.WIDTH(32)) if32 ();

  add_pipe #(.WIDTH(16), .STAGES(4)) u_dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
  add_pipe #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clk(clk), .reset(reset), .bus(if8.slave));
  add_pipe #(.WIDTH(32), .STAGES(8)) u_dut32 (.clk(clk), .reset(reset), .bus(if32.slave));

  assign if16.in_valid = d_valid[0];  assign if16.out_ready = d_oready[0];
  assign if16.a = d_a[0][15:0];       assign if16.b = d_b[0][15:0];
  assign if16.sub = d_sub[0];         assign if16.cin = d_cin[0];
  assign if8.in_valid = d_valid[1];   assign if8.out_ready = d_oready[1];
  assign if8.a = d_a[1][7:0];         assign if8.b = d_b[1][7:0];
  assign if8.sub = d_sub[1];          assign if8.cin = d_cin[1];
  assign if32.in_valid = d_valid[2];  assign if32.out_ready = d_oready[2];
  assign if32.a = d_a[2];             assign if32.b = d_b[2];
  assign if32.sub = d_sub[2];         assign if32.cin = d_cin[2];

  assign s_ready  = {if32.in_ready, if8.in_ready, if16.in_ready};
  assign s_ovalid = {if32.out_valid, if8.out_valid, if16.out_valid};
  assign s_res[0] = {if16.ovf, if16.zero, if16.cout, 16'd0, if16.out};
  assign s_res[1] = {if8.ovf, if8.zero, if8.cout, 24'd0, if8.out};
  assign s_res[2] = {if32.ovf, if32.zero, if32.cout, if32.out};

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc [3] = '{0, 0, 0};
  logic [2:0] acc = '0;
  logic [34:0] sb [3][$];

  typedef struct {
    logic [15:0] a, b;
    logic        sub, cin;
    logic [15:0] o;
    logic        c, v, z;
  } vec_t;
  vec_t tbl [10];

  function automatic int width_of(input int id);
    return (id == 0) ? 16 : (id == 1) ? 8 : 32;
  endfunction

  function automatic int stages_of(input int id);
    return (id == 0) ? 4 : (id == 1) ? 1 : 8;
  endfunction

  // Reference: plain wide add, overflow from operand/result sign bits
  function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic cin);
    logic [63:0] m, am, bx, s, r;
    logic co, ov, z;
    m  = (64'd1 << w) - 64'd1;
    am = {32'd0, a} & m;
    bx = (sub ? ~{32'd0, b} : {32'd0, b}) & m;
    s  = am + bx + {63'd0, (sub ? ~cin : cin)};
    r  = s & m;
    co = s[w];
    ov = (am[w-1] == bx[w-1]) && (r[w-1] != am[w-1]);
    z  = (r == 64'd0);
    return {ov, z, co, r[31:0]};
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on acceptance, pop and compare on retirement
  always @(negedge clk) begin
    for (int id = 0; id < 3; id++) begin
      acc[id] = 1'b0;
      if (reset) begin
        sb[id].delete();
      end else begin
        if (d_valid[id] && s_ready[id]) begin
          sb[id].push_back(model(width_of(id), d_a[id], d_b[id], d_sub[id], d_cin[id]));
          acc[id] = 1'b1;
          n_acc[id]++;
        end
        if (s_ovalid[id] && d_oready[id]) begin
          if (sb[id].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb%0d_unexpected: got %h, expected no result", id, s_res[id]);
          end else begin
            check($sformatf("sb%0d_result", id), {29'd0, s_res[id]}, {29'd0, sb[id].pop_front()});
          end
        end
      end
    end
  end

  task automatic measure_latency(input int id);
    int lat;
    d_a[id] = 32'd1; d_b[id] = 32'd2; d_sub[id] = 1'b0; d_cin[id] = 1'b0;
    d_valid[id] = 1'b1;
    tick();
    d_valid[id] = 1'b0;
    lat = 0;
    while (!s_ovalid[id] && lat < 12) begin
      tick();
      lat++;
    end
    check($sformatf("latency%0d", id), lat, stages_of(id) - 1);
    tick();
  endtask

  task automatic rand_run(input int id, input int n);
    int start, guard;
    start = n_acc[id];
    guard = 0;
    d_valid[id] = 1'b0;
    while (n_acc[id] < start + n && guard < 20000) begin
      if (!d_valid[id] || acc[id]) begin
        d_valid[id] = ($urandom_range(0, 3) != 0);
        d_a[id] = $urandom;
        d_b[id] = $urandom;
        if ($urandom_range(0, 7) == 0) d_a[id] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 7) == 0) d_b[id] = {31'd0, 1'b1};
        d_sub[id] = 1'($urandom_range(0, 1));
        d_cin[id] = 1'($urandom_range(0, 1));
      end
      d_oready[id] = ($urandom_range(0, 9) < 7);
      tick();
      guard++;
    end
    d_valid[id] = 1'b0;
    d_oready[id] = 1'b1;
    repeat (stages_of(id) + 3) tick();
    check($sformatf("rand%0d_count", id), n_acc[id] - start >= n, 1);
    check($sformatf("rand%0d_drain", id), sb[id].size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, last_c, idx, stall_n, seen;
    logic prev_stall;
    logic [34:0] prev_res;

    tbl[0] = '{16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{16'h0010, 16'h0000, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{16'h8000, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    d_valid = '0; d_oready = '1; d_sub = '0; d_cin = '0;
    for (int id = 0; id < 3; id++) begin d_a[id] = '0; d_b[id] = '0; end
    tick(); tick();
    reset = 1'b0;
    for (int id = 0; id < 3; id++)
      check($sformatf("reset_state%0d", id), {s_ready[id], s_ovalid[id], s_res[id]}, {1'b1, 1'b0, 35'd0});

    // Directed vectors on the 16/4 pipe, one at a time, with latency check
    for (int i = 0; i < 10; i++) begin
      int lat;
      d_a[0] = {16'd0, tbl[i].a}; d_b[0] = {16'd0, tbl[i].b};
      d_sub[0] = tbl[i].sub; d_cin[0] = tbl[i].cin;
      d_valid[0] = 1'b1;
      tick();
      d_valid[0] = 1'b0;
      lat = 0;
      while (!s_ovalid[0] && lat < 10) begin
        tick();
        lat++;
      end
      check($sformatf("tbl%0d_latency", i), lat, 3);
      check($sformatf("tbl%0d_result", i), {29'd0, s_res[0]},
            {29'd0, tbl[i].v, tbl[i].z, tbl[i].c, 16'd0, tbl[i].o});
      tick();
    end

    measure_latency(1);
    measure_latency(2);

    // Back-to-back stream of a=i, b=2i
    got = 0; last_c = 0;
    d_sub[0] = 1'b0; d_cin[0] = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (s_ovalid[0]) begin
        check("b2b_out", s_res[0][15:0], 3 * got);
        if (got > 0) check("b2b_consecutive", c, last_c + 1);
        last_c = c;
        got++;
      end
      if (c < 8) begin
        check("b2b_in_ready", s_ready[0], 1);
        d_a[0] = c; d_b[0] = 2 * c; d_valid[0] = 1'b1;
      end else begin
        d_valid[0] = 1'b0;
      end
    end
    check("b2b_count", got, 8);

    // Back-pressure: out_ready low for 5 cycles while streaming
    idx = 0; stall_n = 0; prev_stall = 1'b0; prev_res = '0;
    for (int c = 0; c < 40 && (idx < 8 || sb[0].size() > 0); c++) begin
      d_oready[0] = !(c >= 4 && c < 9);
      if (idx < 8) begin
        d_valid[0] = 1'b1;
        d_a[0] = 32'h0100 + idx * 7; d_b[0] = idx * 3;
        d_sub[0] = idx[0]; d_cin[0] = idx[1];
      end else begin
        d_valid[0] = 1'b0;
      end
      #1;
      if (s_ovalid[0] && !d_oready[0]) begin
        stall_n++;
        check("bp_in_ready_low", s_ready[0], 0);
        if (prev_stall) check("bp_out_hold", {29'd0, s_res[0]}, {29'd0, prev_res});
        prev_stall = 1'b1;
        prev_res = s_res[0];
      end else begin
        prev_stall = 1'b0;
      end
      if (d_valid[0] && s_ready[0]) idx++;
      tick();
    end
    d_valid[0] = 1'b0; d_oready[0] = 1'b1;
    check("bp_stall_cycles", stall_n, 5);
    check("bp_accepted", idx, 8);
    check("bp_drained", sb[0].size(), 0);

    // Reset with three operations in flight, plus one presented during reset
    tick();
    d_sub[0] = 1'b0; d_cin[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_a[0] = 32'h0040 + i; d_b[0] = 32'h0001; d_valid[0] = 1'b1;
      tick();
    end
    d_a[0] = 32'h5555; d_b[0] = 32'h1111;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d_valid[0] = 1'b0;
    check("rst_mid_state", {s_ovalid[0], s_res[0]}, 36'd0);
    seen = 0;
    repeat (12) begin
      tick();
      if (s_ovalid[0]) seen++;
    end
    check("rst_mid_no_results", seen, 0);

    // Random sweep on all three parameter points
    fork
      rand_run(0, 300);
      rand_run(1, 1000);
      rand_run(2, 1000);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the fixed 16-bit ripple adder in the HW#3 arithmetic library.
- Splits the carry chain into STAGES equal slices, one slice per clock; registers the carry between slices.
- Uses a valid/ready handshake on both sides with full back-pressure.
- Sits between operand sources (register file / ALU front end) and consumers needing sum plus flags.

Parameters:
- WIDTH, 16, operand and result width in bits; must be >= 2.
- STAGES, 4, pipeline depth and number of carry-chain slices; must be >= 1 and must divide WIDTH exactly (slice width SW = WIDTH/STAGES).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, sub, cin valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: out = a + b + cin; 1: out = a - b - cin, computed as a + ~b + ~cin.
- cin  input  1  carry-in (add) or borrow-in (sub).
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  WIDTH  sum/difference, mod 2^WIDTH.
- cout  output  1  carry-out (add) or NOT borrow (sub), i.e. the raw carry from the MSB of a + ~b + ~cin.
- ovf  output  1  signed overflow: the carry into the MSB XOR the carry out of the MSB.
- zero  output  1  out == 0.

Behaviour:
- Reset (reset=1 at a rising edge):
  - Clear all stage valid bits, out, cout, ovf and zero to 0.
  - in_ready reads 1 from the first cycle after reset.
  - Discard any in-flight operations; an operation presented while reset=1 is not accepted.
- Stall rule:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - While stalled, every pipeline register holds, including operands, partial sums and carries.
  - No bubble collapsing: the whole pipe advances or holds as one unit.
- Acceptance:
  - Accept when in_valid & in_ready at a rising edge.
  - Stage 1 captures a, b (inverted when sub=1), the effective carry-in, and the slice-0 sum.
  - Stage k (k = 1..STAGES-1) adds slice k of the carried-forward operands with the registered carry from stage k-1.
  - Completed lower slices travel forward unchanged.
- Latency:
  - A result accepted at edge T has out_valid=1 immediately after edge T+STAGES-1, i.e. STAGES edges including the accept edge.
  - Throughput is 1 result/cycle when out_ready=1 continuously.
  - STAGES=1 degenerates to a single registered adder with 1-cycle latency.
- Bubbles: a cycle with no acceptance inserts a valid=0 slot that propagates normally. out_valid=0 slots do not require out_ready.
- Outputs:
  - out, cout, ovf and zero are registered and held stable while out_valid=1 and out_ready=0.
  - When out_valid=0 the values are don't-care, except after reset, when they are 0.
  - zero is computed in the final stage from the complete result.
- Arithmetic:
  - All WIDTH bits participate; no truncation except mod 2^WIDTH on out.
  - ovf uses the MSB carry-in/out of the final slice.
- Simultaneous events:
  - out_ready=1 with out_valid=1 and in_valid=1 in the same cycle: the pipe advances, the result retires and the new input is accepted.
  - reset has priority over every other input.
- in_valid may drop without acceptance (no stickiness required by the block). The source holds a, b, sub, cin stable while in_valid & ~in_ready.

Test Plan:
- Reset then single add, WIDTH=16, STAGES=4: a=0x1234, b=0x0FED, cin=0, sub=0 -> out_valid rises 4 edges after accept; out=0x2221, cout=0, ovf=0, zero=0.
- Carry across all slices: a=0xFFFF, b=0x0001, cin=0 -> out=0x0000, cout=1, zero=1, ovf=0. Repeat with sub=1, a=0x8000, b=0x0001 -> out=0x7FFF, cout=1, ovf=1.
- Back-to-back stream: 8 consecutive accepts (a=i, b=2*i, i=0..7), out_ready=1 throughout -> outputs 0,3,6,...,21 on 8 consecutive cycles, in_ready never drops.
- Back-pressure: hold out_ready=0 for 5 cycles while streaming -> in_ready=0 once out_valid=1; out held stable; no loss or duplication after release; result order preserved.
- Reset mid-operation: accept 3 ops, assert reset for 1 cycle before any retire -> out_valid=0, outputs 0, none of the 3 results ever appears.
- Parameter sweep: WIDTH=8, STAGES=1 (latency 1) and WIDTH=32, STAGES=8 (latency 8). Random 1000 vectors with random sub/cin/out_ready, checked against a reference model for out, cout, ovf, zero.
